// File: rtl/send_frame_lanes_if.sv
// Signal bundle between the multi-lane frame sender, its word source and the serial pins.
// master is the sender's view; slave is the source/receiver view.
interface send_frame_lanes_if #(
  parameter int WORD_WIDTH = 8,
  parameter int WORDS = 2,
  parameter int LANES = 1
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic                  start;
  logic [IDX_W-1:0]      index;
  logic [WORD_WIDTH-1:0] data;
  logic                  serialClock;
  logic [LANES-1:0]      serialData;
  logic                  serialFrame;
  logic                  busy;
  logic                  readyAtNext;
  logic                  done;

  modport master (
    input  start, data,
    output index, serialClock, serialData, serialFrame, busy, readyAtNext, done
  );

  modport slave (
    output start, data,
    input  index, serialClock, serialData, serialFrame, busy, readyAtNext, done
  );
endinterface

// File: rtl/send_frame_lanes.sv
// Multi-lane source-synchronous frame sender: WORDS words, MSB first, LANES bits per beat,
// with a CLOCK_DIV divider on each serialClock half-period and a serialFrame delimiter.
module send_frame_lanes #(
  parameter int WORD_WIDTH = 8,
  parameter int WORDS      = 2,
  parameter int LANES      = 1,
  parameter int CLOCK_DIV  = 1
) (
  input  logic               clock,
  input  logic               resetN,
  send_frame_lanes_if.master bus
);
  localparam int BEATS  = WORD_WIDTH / LANES;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DIV_W  = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

  localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(WORDS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(CLOCK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} stateT;

  stateT                 stateReg, stateNext;
  logic [DIV_W-1:0]      divCountReg, divCountNext;
  logic [BEAT_W-1:0]     beatReg, beatNext;
  logic [IDX_W-1:0]      wordReg, wordNext;
  logic [WORD_WIDTH-1:0] shiftReg, shiftNext;
  logic [IDX_W-1:0]      indexReg, indexNext;
  logic                  serialClockReg, serialClockNext;
  logic [LANES-1:0]      serialDataReg, serialDataNext;
  logic                  serialFrameReg, serialFrameNext;
  logic                  busyReg, busyNext;
  logic                  readyReg, readyNext;
  logic                  doneReg, doneNext;

  logic phaseEnd, lastBeat, lastWord;

  assign phaseEnd = (divCountReg == LAST_DIV);
  assign lastBeat = (beatReg == LAST_BEAT);
  assign lastWord = (wordReg == LAST_WORD);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stateReg       <= IDLE;
      divCountReg    <= '0;
      beatReg        <= '0;
      wordReg        <= '0;
      shiftReg       <= '0;
      indexReg       <= '0;
      serialClockReg <= 1'b1;
      serialDataReg  <= '0;
      serialFrameReg <= 1'b0;
      busyReg        <= 1'b0;
      readyReg       <= 1'b0;
      doneReg        <= 1'b0;
    end else begin
      stateReg       <= stateNext;
      divCountReg    <= divCountNext;
      beatReg        <= beatNext;
      wordReg        <= wordNext;
      shiftReg       <= shiftNext;
      indexReg       <= indexNext;
      serialClockReg <= serialClockNext;
      serialDataReg  <= serialDataNext;
      serialFrameReg <= serialFrameNext;
      busyReg        <= busyNext;
      readyReg       <= readyNext;
      doneReg        <= doneNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    divCountNext = divCountReg;
    beatNext     = beatReg;
    wordNext     = wordReg;
    case (stateReg)
      IDLE: begin
        if (bus.start) begin
          stateNext    = LOW;
          divCountNext = '0;
          beatNext     = '0;
          wordNext     = '0;
        end
      end
      LOW: begin
        if (phaseEnd) begin
          stateNext    = HIGH;
          divCountNext = '0;
        end else begin
          divCountNext = divCountReg + DIV_W'(1);
        end
      end
      HIGH: begin
        if (phaseEnd) begin
          divCountNext = '0;
          if (!lastBeat) begin
            stateNext = LOW;
            beatNext  = beatReg + BEAT_W'(1);
          end else if (!lastWord) begin
            stateNext = LOW;
            beatNext  = '0;
            wordNext  = wordReg + IDX_W'(1);
          end else begin
            stateNext = IDLE;
            beatNext  = '0;
            wordNext  = '0;
          end
        end else begin
          divCountNext = divCountReg + DIV_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so every pin comes straight from a flop.
  always_comb begin
    shiftNext       = shiftReg;
    indexNext       = indexReg;
    serialClockNext = serialClockReg;
    serialDataNext  = serialDataReg;
    serialFrameNext = serialFrameReg;
    busyNext        = (stateNext != IDLE);
    doneNext        = 1'b0;
    readyNext       = (stateNext == HIGH) && (divCountNext == LAST_DIV) && lastBeat && lastWord;
    case (stateReg)
      IDLE: begin
        if (bus.start) begin
          shiftNext       = bus.data;
          serialDataNext  = bus.data[WORD_WIDTH-1 -: LANES];
          serialClockNext = 1'b0;
          serialFrameNext = 1'b1;
        end
      end
      LOW: begin
        if (phaseEnd) begin
          serialClockNext = 1'b1;
          // Advancing index a half-period early lets the source settle before the latch.
          if (lastBeat && !lastWord) begin
            indexNext = indexReg + IDX_W'(1);
          end
        end
      end
      HIGH: begin
        if (phaseEnd) begin
          if (!lastBeat) begin
            shiftNext       = shiftReg << LANES;
            serialDataNext  = shiftNext[WORD_WIDTH-1 -: LANES];
            serialClockNext = 1'b0;
          end else if (!lastWord) begin
            shiftNext       = bus.data;
            serialDataNext  = bus.data[WORD_WIDTH-1 -: LANES];
            serialClockNext = 1'b0;
          end else begin
            serialClockNext = 1'b1;
            serialDataNext  = '0;
            serialFrameNext = 1'b0;
            indexNext       = '0;
            doneNext        = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.index       = indexReg;
  assign bus.serialClock = serialClockReg;
  assign bus.serialData  = serialDataReg;
  assign bus.serialFrame = serialFrameReg;
  assign bus.busy        = busyReg;
  assign bus.readyAtNext = readyReg;
  assign bus.done        = doneReg;
endmodule
